song_player: RTL and testbench
==============================

SONG_PLAYER -- requirements
Module: song_player

Interface
REQ-001 SHALL have parameter DIV_W, default 17: width of tone divider output.
REQ-002 SHALL have parameter LEN, default 110: number of steps in song table, 1..DEPTH.
REQ-003 SHALL have parameter DEPTH, default 128: song table capacity, power of two; ADDR_W = log2(DEPTH).
REQ-004 SHALL have parameter DUR_W, default 4: width of per-step duration field, in tempo ticks.
REQ-005 SHALL have parameter GAP_TICKS, default 1: silent ticks at end of each note (gap feature only).
REQ-006 SHALL have port clk  input  1  system clock (2.08 MHz); only clock.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port tempo_tick  input  1  single-cycle strobe, synchronous to clk, one per tempo tick.
REQ-009 SHALL have port start  input  1  single-cycle request to play from step 0.
REQ-010 SHALL have port stop  input  1  single-cycle request to abort playback.
REQ-011 SHALL have port loop_en  input  1  level; repeat song when high.
REQ-012 SHALL have port div  output  DIV_W  tone divider to wave generator; 0 when silent.
REQ-013 SHALL have port enable  output  1  tone enable to wave generator.
REQ-014 SHALL have port busy  output  1  high while not IDLE.
REQ-015 SHALL have port step  output  ADDR_W  current step index.
REQ-016 SHALL have port done  output  1  single-cycle pulse when a non-looping song ends.

Function
REQ-017 SHALL implement states IDLE, PLAY; all outputs registered.
REQ-018 Each table entry SHALL be {note_code[5:0], dur[DUR_W-1:0]}; note_code 0 = rest; dur 0 treated as 1.
REQ-019 div SHALL equal NOTE_DIV[note_code] of current step; enable SHALL be high only in PLAY with note_code != 0 and not in gap window.
REQ-020 IDLE + start: next clk edge state=PLAY, step=0, tick count=0, div/enable of step 0 valid same edge (1-cycle latency).
REQ-021 In PLAY each tempo_tick SHALL increment tick count; tempo_tick outside PLAY SHALL be ignored.
REQ-022 On tempo_tick with tick count = dur-1: step advances, tick count=0, new div/enable valid same edge.
REQ-023 On advance from step LEN-1: loop_en=1 -> step 0 without gap; loop_en=0 -> IDLE, done=1 one cycle, step=0, enable=0, div=0.
REQ-024 stop in PLAY SHALL force IDLE next edge, enable=0, div=0, no done pulse.
REQ-025 start in PLAY SHALL restart at step 0, tick count 0.
REQ-026 start and stop same cycle: stop wins.
REQ-027 start and tempo_tick same cycle in IDLE: tick ignored; counting begins with next tick.
REQ-028 Step counter SHALL never exceed LEN-1; tick counter SHALL never exceed DUR_W bits.

Reset
REQ-029 rst high SHALL asynchronously force IDLE, step=0, tick count=0, div=0, enable=0, busy=0, done=0.
REQ-030 rst asserted mid-note SHALL silence output immediately without waiting for clk.

Configuration
REQ-031 Macro SONG_PLAYER_GAP_EN defined: enable SHALL be low during final min(GAP_TICKS, dur-1) ticks of each note; div unchanged.
REQ-032 SONG_PLAYER_GAP_EN undefined: no gap logic, GAP_TICKS ignored, consecutive equal notes sound continuous.

Structure
REQ-033 Package song_pkg SHALL hold note_code constants (REST, L1..L7, M1..M7, H1..H7), NOTE_DIV table, state enum.
REQ-034 Song contents SHALL live in sub-module song_rom (combinational, step -> entry), replaceable per song.

Verification
REQ-035 rst, start, 3-step table {M6 d2, REST d1, H1 d1}, loop_en=0 -> div=M6 enable=1 for 2 ticks, enable=0 1 tick, H1 1 tick, done pulse, busy=0.
REQ-036 Same table, loop_en=1 -> after step 2 tick, step=0 div=M6, no done, sequence repeats 3 times identically.
REQ-037 stop on cycle after 1st tick -> next edge enable=0, div=0, busy=0, done=0.
REQ-038 start+stop same cycle while IDLE -> stays IDLE; start during step 2 -> step=0 next edge.
REQ-039 GAP_EN, GAP_TICKS=1, two M3 d2 steps -> enable pattern 1,0,1,0 per tick; without macro 1,1,1,1.
REQ-040 rst pulse between clk edges mid-note -> enable=0 before next edge; entry with dur=0 lasts exactly 1 tick.

Source files
------------

// File: rtl/song_pkg.sv
// Shared definitions for the song player: note codes, tone divider table
// and the player state encoding.
package song_pkg;

    localparam int NOTE_W = 6;

    // Note codes: 0 is a rest, then low / middle / high octaves of C major.
    localparam logic [NOTE_W-1:0] REST = 6'd0;
    localparam logic [NOTE_W-1:0] L1 = 6'd1,  L2 = 6'd2,  L3 = 6'd3,  L4 = 6'd4;
    localparam logic [NOTE_W-1:0] L5 = 6'd5,  L6 = 6'd6,  L7 = 6'd7;
    localparam logic [NOTE_W-1:0] M1 = 6'd8,  M2 = 6'd9,  M3 = 6'd10, M4 = 6'd11;
    localparam logic [NOTE_W-1:0] M5 = 6'd12, M6 = 6'd13, M7 = 6'd14;
    localparam logic [NOTE_W-1:0] H1 = 6'd15, H2 = 6'd16, H3 = 6'd17, H4 = 6'd18;
    localparam logic [NOTE_W-1:0] H5 = 6'd19, H6 = 6'd20, H7 = 6'd21;

    // Half-period counts at 2.08 MHz: round(1_040_000 / f_note). Rest and
    // unused codes give 0 so the wave generator stays silent.
    localparam logic [16:0] NOTE_DIV [64] = '{
        1: 17'd7950,  2: 17'd7083,  3: 17'd6310,  4: 17'd5956,
        5: 17'd5306,  6: 17'd4727,  7: 17'd4212,
        8: 17'd3975,  9: 17'd3542,  10: 17'd3155, 11: 17'd2978,
        12: 17'd2653, 13: 17'd2364, 14: 17'd2106,
        15: 17'd1988, 16: 17'd1771, 17: 17'd1578, 18: 17'd1489,
        19: 17'd1327, 20: 17'd1182, 21: 17'd1053,
        default: 17'd0
    };

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_e;

endpackage

// File: rtl/song_rom.sv
// Song contents: combinational step -> {note_code, duration} lookup.
// Replace this file to change the tune.
module song_rom
    import song_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DUR_W  = 4
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [NOTE_W-1:0] note_o,
    output logic [DUR_W-1:0]  dur_o
);

    // Opening phrase followed by a repeating middle-octave scale at two ticks per note.
    always_comb begin
        note_o = REST;
        dur_o  = DUR_W'(1);
        case (addr_i)
            ADDR_W'(0): begin note_o = M6;   dur_o = DUR_W'(2); end
            ADDR_W'(1): begin note_o = REST; dur_o = DUR_W'(1); end
            ADDR_W'(2): begin note_o = H1;   dur_o = DUR_W'(1); end
            ADDR_W'(3): begin note_o = M3;   dur_o = DUR_W'(2); end
            ADDR_W'(4): begin note_o = M3;   dur_o = DUR_W'(2); end
            ADDR_W'(5): begin note_o = M5;   dur_o = DUR_W'(0); end
            default: begin
                note_o = NOTE_W'(int'(M1) + (int'(addr_i) % 7));
                dur_o  = DUR_W'(2);
            end
        endcase
    end

endmodule

// File: rtl/song_player.sv
// Song player: steps through song_rom at tempo_tick rate and drives a tone
// divider / enable pair for a wave generator. All outputs are registered.
// Optional feature macro: SONG_PLAYER_GAP_EN (silent gap at the end of each note).
module song_player
    import song_pkg::*;
#(
    parameter int  DIV_W     = 17,
    parameter int  LEN       = 110,
    parameter int  DEPTH     = 128,
    parameter int  DUR_W     = 4,
    parameter int  GAP_TICKS = 1,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tempo_tick,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    output logic [DIV_W-1:0]  div,
    output logic              enable,
    output logic              busy,
    output logic [ADDR_W-1:0] step,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_STEP = ADDR_W'(LEN - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   step_q, step_d;
    logic [DUR_W-1:0]    tick_q, tick_d;
    logic [DUR_W-1:0]    last_q, last_d;     // index of final tick of the current note
    logic [DIV_W-1:0]    div_q, div_d;
    logic                enable_q, enable_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [NOTE_W-1:0]   rom_note;
    logic [DUR_W-1:0]    rom_dur;
    logic                in_gap;

    // The ROM is addressed by the next step so new div/enable land on the same edge.
    song_rom #(.ADDR_W(ADDR_W), .DUR_W(DUR_W)) u_rom (
        .addr_i (step_d),
        .note_o (rom_note),
        .dur_o  (rom_dur)
    );

    // A zero duration plays as one tick.
    assign last_d = (rom_dur == '0) ? '0 : rom_dur - DUR_W'(1);

`ifdef SONG_PLAYER_GAP_EN
    int gap_len;
    // Silence the final min(GAP_TICKS, dur-1) ticks of each note.
    always_comb begin
        gap_len = (GAP_TICKS < int'(last_d)) ? GAP_TICKS : int'(last_d);
        in_gap  = int'(tick_d) > (int'(last_d) - gap_len);
    end
`else
    assign in_gap = 1'b0;
`endif

    // State register and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            step_q   <= '0;
            tick_q   <= '0;
            last_q   <= '0;
            div_q    <= '0;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            tick_q   <= tick_d;
            last_q   <= last_d;
            div_q    <= div_d;
            enable_q <= enable_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next state: start/stop handling (stop wins), tick counting and step advance.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        tick_d  = tick_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = PLAY;
                    step_d  = '0;
                    tick_d  = '0;
                end
            end
            PLAY: begin
                if (stop) begin
                    state_d = IDLE;
                    step_d  = '0;
                    tick_d  = '0;
                end else if (start) begin
                    step_d = '0;
                    tick_d = '0;
                end else if (tempo_tick) begin
                    if (tick_q >= last_q) begin
                        tick_d = '0;
                        if (step_q >= LAST_STEP) begin
                            step_d = '0;
                            if (!loop_en) begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            step_d = step_q + ADDR_W'(1);
                        end
                    end else begin
                        tick_d = tick_q + DUR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the next state and the next step's ROM entry.
    always_comb begin
        busy_d   = (state_d == PLAY);
        div_d    = '0;
        enable_d = 1'b0;
        if (state_d == PLAY) begin
            div_d    = DIV_W'(NOTE_DIV[rom_note]);
            enable_d = (rom_note != REST) && !in_gap;
        end
    end

    assign div    = div_q;
    assign enable = enable_q;
    assign busy   = busy_q;
    assign step   = step_q;
    assign done   = done_q;

endmodule

// File: tb/tb_song_player.sv
// Directed bench for song_player. Instance a plays a 3-step song, instance b
// the first 6 steps of the same ROM (adds two M3 d2 notes and an M5 d0 note).
module tb_song_player;

`ifdef SONG_PLAYER_GAP_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif

    localparam logic [31:0] D_M6 = 32'd2364;
    localparam logic [31:0] D_H1 = 32'd1988;
    localparam logic [31:0] D_M3 = 32'd3155;
    localparam logic [31:0] D_M5 = 32'd2653;

    logic        clk = 1'b0;
    logic        rst, tempo_tick, start, stop, loop_en;
    logic [16:0] div_a, div_b;
    logic        enable_a, enable_b, busy_a, busy_b, done_a, done_b;
    logic [6:0]  step_a, step_b;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;

    // clock
    always #5 clk = ~clk;

    song_player #(.LEN(3)) u_a (
        .clk(clk), .rst(rst), .tempo_tick(tempo_tick), .start(start), .stop(stop),
        .loop_en(loop_en), .div(div_a), .enable(enable_a), .busy(busy_a),
        .step(step_a), .done(done_a)
    );

    song_player #(.LEN(6)) u_b (
        .clk(clk), .rst(rst), .tempo_tick(tempo_tick), .start(start), .stop(stop),
        .loop_en(loop_en), .div(div_b), .enable(enable_b), .busy(busy_b),
        .step(step_b), .done(done_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock cycle with the given strobes; outputs sampled 1 ns after the edge.
    task automatic cycle(input logic s, input logic p, input logic t);
        @(negedge clk);
        start      = s;
        stop       = p;
        tempo_tick = t;
        @(posedge clk);
        #1;
        start      = 1'b0;
        stop       = 1'b0;
        tempo_tick = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; tempo_tick = 1'b0; loop_en = 1'b0;
        #12;
        check("rst_div", 32'(div_a), 32'd0);
        check("rst_en", 32'(enable_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_step", 32'(step_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Non-looping 3-step song.
        cycle(1, 0, 0);
        check("a_start_busy", 32'(busy_a), 32'd1);
        check("a_start_step", 32'(step_a), 32'd0);
        check("a_start_div", 32'(div_a), D_M6);
        check("a_start_en", 32'(enable_a), 32'd1);
        cycle(0, 0, 1);
        check("a_t1_div", 32'(div_a), D_M6);
        check("a_t1_en", 32'(enable_a), GAP ? 32'd0 : 32'd1);
        check("a_t1_step", 32'(step_a), 32'd0);
        cycle(0, 0, 0);
        check("a_hold_div", 32'(div_a), D_M6);
        cycle(0, 0, 1);
        check("a_rest_step", 32'(step_a), 32'd1);
        check("a_rest_en", 32'(enable_a), 32'd0);
        check("a_rest_div", 32'(div_a), 32'd0);
        cycle(0, 0, 1);
        check("a_h1_step", 32'(step_a), 32'd2);
        check("a_h1_div", 32'(div_a), D_H1);
        check("a_h1_en", 32'(enable_a), 32'd1);
        cycle(0, 0, 1);
        check("a_end_done", 32'(done_a), 32'd1);
        check("a_end_busy", 32'(busy_a), 32'd0);
        check("a_end_step", 32'(step_a), 32'd0);
        check("a_end_en", 32'(enable_a), 32'd0);
        check("a_end_div", 32'(div_a), 32'd0);
        cycle(0, 0, 0);
        check("a_done_pulse", 32'(done_a), 32'd0);

        // Looping: three identical passes.
        loop_en = 1'b1;
        cycle(1, 0, 0);
        check("loop_start_div", 32'(div_a), D_M6);
        for (int r = 0; r < 3; r++) begin
            exp_q.push_back(D_M6);
            exp_q.push_back(32'd0);
            exp_q.push_back(D_H1);
            exp_q.push_back(D_M6);
        end
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) begin
                cycle(0, 0, 1);
                e = exp_q.pop_front();
                check("loop_div", 32'(div_a), e);
            end
            check("loop_step", 32'(step_a), 32'd0);
            check("loop_done", 32'(done_a), 32'd0);
            check("loop_busy", 32'(busy_a), 32'd1);
        end
        loop_en = 1'b0;

        // Stop after first tick.
        cycle(1, 0, 0);
        cycle(0, 0, 1);
        cycle(0, 1, 0);
        check("stop_en", 32'(enable_a), 32'd0);
        check("stop_div", 32'(div_a), 32'd0);
        check("stop_busy", 32'(busy_a), 32'd0);
        check("stop_done", 32'(done_a), 32'd0);

        // start+stop in IDLE, then restart from step 2.
        cycle(1, 1, 0);
        check("ss_busy", 32'(busy_a), 32'd0);
        check("ss_en", 32'(enable_a), 32'd0);
        cycle(1, 0, 0);
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        check("rs_pre_step", 32'(step_a), 32'd2);
        cycle(1, 0, 0);
        check("rs_step", 32'(step_a), 32'd0);
        check("rs_div", 32'(div_a), D_M6);
        check("rs_busy", 32'(busy_a), 32'd1);
        cycle(0, 1, 0);

        // start+tick in IDLE: that tick is not counted.
        cycle(1, 0, 1);
        check("st_step0", 32'(step_a), 32'd0);
        cycle(0, 0, 1);
        check("st_step1", 32'(step_a), 32'd0);
        cycle(0, 0, 1);
        check("st_step2", 32'(step_a), 32'd1);
        cycle(0, 1, 0);

        // Instance b: two M3 d2 notes, then M5 with dur 0.
        cycle(1, 0, 0);
        for (int k = 0; k < 4; k++) cycle(0, 0, 1);
        check("b_m3a_step", 32'(step_b), 32'd3);
        check("b_m3a_div", 32'(div_b), D_M3);
        check("b_m3a_en0", 32'(enable_b), 32'd1);
        cycle(0, 0, 1);
        check("b_m3a_en1", 32'(enable_b), GAP ? 32'd0 : 32'd1);
        check("b_m3a_div1", 32'(div_b), D_M3);
        cycle(0, 0, 1);
        check("b_m3b_step", 32'(step_b), 32'd4);
        check("b_m3b_en0", 32'(enable_b), 32'd1);
        cycle(0, 0, 1);
        check("b_m3b_en1", 32'(enable_b), GAP ? 32'd0 : 32'd1);
        cycle(0, 0, 1);
        check("b_d0_step", 32'(step_b), 32'd5);
        check("b_d0_div", 32'(div_b), D_M5);
        check("b_d0_en", 32'(enable_b), 32'd1);
        cycle(0, 0, 1);
        check("b_d0_done", 32'(done_b), 32'd1);
        check("b_d0_busy", 32'(busy_b), 32'd0);

        // Asynchronous reset between clock edges.
        cycle(1, 0, 0);
        check("ar_pre_en", 32'(enable_b), 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("ar_en", 32'(enable_b), 32'd0);
        check("ar_div", 32'(div_b), 32'd0);
        check("ar_busy", 32'(busy_b), 32'd0);
        #1;
        rst = 1'b0;
        cycle(0, 0, 1);
        check("ar_idle_tick", 32'(busy_b), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
